// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - RV32I main control decoder with registered ID/EX control word
module decode_ctrl_stage #(
  parameter bit EN_U_TYPE = 1'b1,
  parameter bit EN_JALR   = 1'b1,
  parameter bit EN_HAZARD = 1'b1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [31:0]          id_instr,
  input  logic                 ex_stall,
  input  logic                 ex_flush,
  output logic                 ex_valid,
  output logic [4:0]           ex_rd,
  output logic [2:0]           ex_imm_sel,
  output logic [1:0]           ex_alu_type_sel,
  output logic                 ex_a_pc_sel,
  output logic                 ex_b_imm_sel,
  output logic                 ex_branch,
  output logic                 ex_jump,
  output logic                 ex_jalr,
  output logic                 ex_memwrite_en,
  output logic                 ex_regwrite_en,
  output logic [1:0]           ex_wb_sel,
  output logic                 hazard_stall,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic [1:0] alu_type_sel;
    logic       a_pc_sel;
    logic       b_imm_sel;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       memwrite_en;
    logic       regwrite_en;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    ctrl_t      ctrl;
  } ex_t;

  logic [6:0] opcode;
  logic [4:0] rd_in;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       unused_instr_bits;

  ctrl_t dec;
  logic  rs2_used;

  ex_t                 ex_q, ex_d;
  logic [ILL_CNT_W-1:0] cnt_q, cnt_d;

  assign opcode = id_instr[6:0];
  assign rd_in  = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

  // Opcode decode into a control word; rs2 only matters for R, S and B formats
  always_comb begin
    dec      = '0;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        dec.alu_type_sel = 2'b01;
        dec.regwrite_en  = 1'b1;
        rs2_used         = 1'b1;
      end
      OP_I: begin
        dec.alu_type_sel = 2'b01;
        dec.b_imm_sel    = 1'b1;
        dec.regwrite_en  = 1'b1;
      end
      OP_LOAD: begin
        dec.b_imm_sel   = 1'b1;
        dec.regwrite_en = 1'b1;
        dec.wb_sel      = 2'b01;
      end
      OP_STORE: begin
        dec.imm_sel     = 3'b001;
        dec.b_imm_sel   = 1'b1;
        dec.memwrite_en = 1'b1;
        rs2_used        = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm_sel      = 3'b010;
        dec.alu_type_sel = 2'b10;
        dec.branch       = 1'b1;
        rs2_used         = 1'b1;
      end
      OP_JAL: begin
        dec.imm_sel     = 3'b011;
        dec.a_pc_sel    = 1'b1;
        dec.b_imm_sel   = 1'b1;
        dec.jump        = 1'b1;
        dec.regwrite_en = 1'b1;
        dec.wb_sel      = 2'b10;
      end
      OP_JALR: begin
        if (EN_JALR) begin
          dec.b_imm_sel   = 1'b1;
          dec.jump        = 1'b1;
          dec.jalr        = 1'b1;
          dec.regwrite_en = 1'b1;
          dec.wb_sel      = 2'b10;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EN_U_TYPE) begin
          dec.imm_sel      = 3'b100;
          dec.alu_type_sel = 2'b11;
          dec.b_imm_sel    = 1'b1;
          dec.regwrite_en  = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (EN_U_TYPE) begin
          dec.imm_sel     = 3'b100;
          dec.a_pc_sel    = 1'b1;
          dec.b_imm_sel   = 1'b1;
          dec.regwrite_en = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_FENCE, OP_SYSTEM: begin
        dec = '0;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally discarded, so never request them
    if (rd_in == 5'd0) begin
      dec.regwrite_en = 1'b0;
    end
  end

  // Load-use hazard: a load in EX whose destination feeds this instruction
  assign hazard_stall = EN_HAZARD && id_valid && ex_q.valid &&
                        (ex_q.ctrl.wb_sel == 2'b01) && (ex_q.rd != 5'd0) &&
                        ((ex_q.rd == rs1) || (rs2_used && (ex_q.rd == rs2)));

  // ID/EX next state: flush beats stall, stall holds, hazard inserts a bubble
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (ex_flush) begin
      ex_d = '0;
    end else if (!ex_stall) begin
      if (hazard_stall || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d.valid = 1'b1;
        ex_d.rd    = rd_in;
        ex_d.ctrl  = dec;
        if (dec.illegal && !(&cnt_q)) begin
          cnt_d = cnt_q + ILL_CNT_W'(1);
        end
      end
    end
  end

  // ID/EX register and illegal-opcode counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid        = ex_q.valid;
  assign ex_rd           = ex_q.rd;
  assign ex_imm_sel      = ex_q.ctrl.imm_sel;
  assign ex_alu_type_sel = ex_q.ctrl.alu_type_sel;
  assign ex_a_pc_sel     = ex_q.ctrl.a_pc_sel;
  assign ex_b_imm_sel    = ex_q.ctrl.b_imm_sel;
  assign ex_branch       = ex_q.ctrl.branch;
  assign ex_jump         = ex_q.ctrl.jump;
  assign ex_jalr         = ex_q.ctrl.jalr;
  assign ex_memwrite_en  = ex_q.ctrl.memwrite_en;
  assign ex_regwrite_en  = ex_q.ctrl.regwrite_en;
  assign ex_wb_sel       = ex_q.ctrl.wb_sel;
  assign illegal         = ex_q.ctrl.illegal;
  assign ill_count       = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - scoreboard bench for decode_ctrl_stage
module tb_decode_ctrl_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_stall;
  logic        ex_flush;

  logic       ex_valid, ex_a_pc_sel, ex_b_imm_sel, ex_branch, ex_jump, ex_jalr;
  logic       ex_memwrite_en, ex_regwrite_en, hazard_stall, illegal;
  logic [4:0] ex_rd;
  logic [2:0] ex_imm_sel;
  logic [1:0] ex_alu_type_sel, ex_wb_sel;
  logic [7:0] ill_count;

  logic       u2_valid, u2_a_pc, u2_b_imm, u2_branch, u2_jump, u2_jalr;
  logic       u2_memw, u2_regw, u2_hazard, u2_illegal;
  logic [4:0] u2_rd;
  logic [2:0] u2_imm;
  logic [1:0] u2_alu, u2_wb;
  logic [7:0] u2_count;

  decode_ctrl_stage #(.EN_U_TYPE(1'b1), .EN_JALR(1'b1), .EN_HAZARD(1'b1), .ILL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_imm_sel(ex_imm_sel), .ex_alu_type_sel(ex_alu_type_sel), .ex_a_pc_sel(ex_a_pc_sel),
    .ex_b_imm_sel(ex_b_imm_sel), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_memwrite_en(ex_memwrite_en), .ex_regwrite_en(ex_regwrite_en), .ex_wb_sel(ex_wb_sel),
    .hazard_stall(hazard_stall), .illegal(illegal), .ill_count(ill_count)
  );

  decode_ctrl_stage #(.EN_U_TYPE(1'b0), .EN_JALR(1'b1), .EN_HAZARD(1'b1), .ILL_CNT_W(8)) dut_nou (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_valid(u2_valid), .ex_rd(u2_rd),
    .ex_imm_sel(u2_imm), .ex_alu_type_sel(u2_alu), .ex_a_pc_sel(u2_a_pc),
    .ex_b_imm_sel(u2_b_imm), .ex_branch(u2_branch), .ex_jump(u2_jump), .ex_jalr(u2_jalr),
    .ex_memwrite_en(u2_memw), .ex_regwrite_en(u2_regw), .ex_wb_sel(u2_wb),
    .hazard_stall(u2_hazard), .illegal(u2_illegal), .ill_count(u2_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [20:0] exp_q[$];
  int          cnt_q[$];
  logic [20:0] cur;
  int          mcnt;

  // word layout: {valid, rd, imm, alu, a_pc, b_imm, branch, jump, jalr, memw, regw, wb, illegal}
  wire [20:0] obs  = {ex_valid, ex_rd, ex_imm_sel, ex_alu_type_sel, ex_a_pc_sel, ex_b_imm_sel,
                      ex_branch, ex_jump, ex_jalr, ex_memwrite_en, ex_regwrite_en, ex_wb_sel, illegal};
  wire [20:0] obs2 = {u2_valid, u2_rd, u2_imm, u2_alu, u2_a_pc, u2_b_imm,
                      u2_branch, u2_jump, u2_jalr, u2_memw, u2_regw, u2_wb, u2_illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // imm alu apc bimm br j jalr mw rw wb ill
  function automatic logic [14:0] ref_dec(input logic [31:0] ins);
    logic [14:0] w;
    case (ins[6:0])
      7'b0110011: w = 15'b000_01_0_0_0_0_0_0_1_00_0;
      7'b0010011: w = 15'b000_01_0_1_0_0_0_0_1_00_0;
      7'b0000011: w = 15'b000_00_0_1_0_0_0_0_1_01_0;
      7'b0100011: w = 15'b001_00_0_1_0_0_0_1_0_00_0;
      7'b1100011: w = 15'b010_10_0_0_1_0_0_0_0_00_0;
      7'b1101111: w = 15'b011_00_1_1_0_1_0_0_1_10_0;
      7'b1100111: w = 15'b000_00_0_1_0_1_1_0_1_10_0;
      7'b0110111: w = 15'b100_11_0_1_0_0_0_0_1_00_0;
      7'b0010111: w = 15'b100_00_1_1_0_0_0_0_1_00_0;
      7'b0001111, 7'b1110011: w = 15'b0;
      default: w = 15'b1;
    endcase
    if (ins[11:7] == 5'd0) w[3] = 1'b0;
    return w;
  endfunction

  function automatic logic model_hz(input logic [31:0] ins, input logic idv);
    logic use2;
    use2 = (ins[6:0] == 7'b0110011) || (ins[6:0] == 7'b0100011) || (ins[6:0] == 7'b1100011);
    return idv && cur[20] && (cur[2:1] == 2'b01) && (cur[19:15] != 5'd0) &&
           ((cur[19:15] == ins[19:15]) || (use2 && (cur[19:15] == ins[24:20])));
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    mk = {7'b0, rs2[4:0], rs1[4:0], 3'b0, rd[4:0], op};
  endfunction

  // drive one ID slot, predict the EX word one clock later, compare after the edge
  task automatic step(input logic [31:0] ins, input logic idv, input logic stl, input logic fl);
    logic        hz;
    logic [14:0] d;
    logic [20:0] nxt;
    int          c;
    @(negedge clk);
    id_instr = ins; id_valid = idv; ex_stall = stl; ex_flush = fl;
    #1;
    hz = model_hz(ins, idv);
    check_eq("hazard_stall", {31'b0, hazard_stall}, {31'b0, hz});
    d = ref_dec(ins);
    c = mcnt;
    if (fl) nxt = '0;
    else if (stl) nxt = cur;
    else if (hz || !idv) nxt = '0;
    else begin
      nxt = {1'b1, ins[11:7], d};
      if (d[0] && c < 255) c++;
    end
    exp_q.push_back(nxt);
    cnt_q.push_back(c);
    cur  = nxt;
    mcnt = c;
    @(posedge clk);
    #1;
    check_eq("ex_word", {11'b0, obs}, {11'b0, exp_q.pop_front()});
    check_eq("ill_count", {24'b0, ill_count}, cnt_q.pop_front());
  endtask

  initial begin
    logic [6:0] ops[11];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; ex_stall = 1'b0; ex_flush = 1'b0;
    cur = '0; mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_word", {11'b0, obs}, 32'd0);
    check_eq("reset_count", {24'b0, ill_count}, 32'd0);
    check_eq("reset_hazard", {31'b0, hazard_stall}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // every legal opcode with rd=5
    foreach (ops[i]) step(mk(ops[i], 5, 0, 0), 1'b1, 1'b0, 1'b0);
    // explicit spot checks for LUI and JALR
    step(mk(7'b0110111, 5, 0, 0), 1'b1, 1'b0, 1'b0);
    check_eq("lui_word", {11'b0, obs}, {11'b0, 1'b1, 5'd5, 15'b100_11_0_1_0_0_0_0_1_00_0});
    step(mk(7'b1100111, 5, 0, 0), 1'b1, 1'b0, 1'b0);
    check_eq("jalr_word", {11'b0, obs}, {11'b0, 1'b1, 5'd5, 15'b000_00_0_1_0_1_1_0_1_10_0});

    // load-use via rs1: bubble then ADD enters
    step(mk(7'b0000011, 3, 1, 0), 1'b1, 1'b0, 1'b0);
    step(mk(7'b0110011, 4, 3, 1), 1'b1, 1'b0, 1'b0);
    check_eq("bubble_valid", {31'b0, ex_valid}, 32'd0);
    step(mk(7'b0110011, 4, 3, 1), 1'b1, 1'b0, 1'b0);
    check_eq("add_after_bubble", {31'b0, ex_valid}, 32'd1);
    // load-use via rs2
    step(mk(7'b0000011, 3, 1, 0), 1'b1, 1'b0, 1'b0);
    step(mk(7'b0110011, 4, 1, 3), 1'b1, 1'b0, 1'b0);
    step(mk(7'b0110011, 4, 1, 3), 1'b1, 1'b0, 1'b0);
    // ADDI with imm bits [24:20]=3 is not a hazard
    step(mk(7'b0000011, 3, 1, 0), 1'b1, 1'b0, 1'b0);
    step(mk(7'b0010011, 4, 1, 3), 1'b1, 1'b0, 1'b0);

    // flush together with stall squashes the ADDI
    step(mk(7'b0010011, 6, 1, 0), 1'b1, 1'b0, 1'b0);
    step(mk(7'b0010011, 7, 1, 0), 1'b1, 1'b1, 1'b1);
    // stall alone holds the ADDI for three cycles
    step(mk(7'b0010011, 6, 1, 0), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(mk(7'b0110011, 9, 2, 2), 1'b1, 1'b1, 1'b0);

    // illegal opcodes: flushed, stalled and invalid ones do not count
    step(32'h0000_00ff, 1'b1, 1'b0, 1'b1);
    step(32'h0000_00ff, 1'b1, 1'b1, 1'b0);
    step(32'h0000_00ff, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) step(32'h0000_00ff, 1'b1, 1'b0, 1'b0);
    check_eq("ill_saturated", {24'b0, ill_count}, 32'd255);
    step(32'h0000_00ff, 1'b0, 1'b0, 1'b0);
    check_eq("ill_hold_invalid", {24'b0, ill_count}, 32'd255);

    // U-type disabled instance flags LUI illegal; ADDI x0 never writes
    step(mk(7'b0110111, 5, 0, 0), 1'b1, 1'b0, 1'b0);
    check_eq("nou_lui_word", {11'b0, obs2}, {11'b0, 1'b1, 5'd5, 15'b1});
    step(mk(7'b0010011, 0, 0, 1), 1'b1, 1'b0, 1'b0);
    check_eq("addi_x0_regw", {31'b0, ex_regwrite_en}, 32'd0);
    check_eq("addi_x0_valid", {31'b0, ex_valid}, 32'd1);

    // asynchronous reset mid-stall
    step(mk(7'b0010011, 6, 1, 0), 1'b1, 1'b0, 1'b0);
    step(mk(7'b0110011, 4, 1, 2), 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_word", {11'b0, obs}, 32'd0);
    check_eq("async_rst_count", {24'b0, ill_count}, 32'd0);
    cur = '0; mcnt = 0;
    @(negedge clk) rst = 1'b0;
    step(mk(7'b0110011, 4, 1, 2), 1'b1, 1'b0, 1'b0);
    check_eq("add_after_reset", {27'b0, ex_rd}, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
